mcram_loader: RTL and testbench

- Writer side of the 1024x56 microcode store: fills a RAM-based microcode array from a byte stream (debug/boot channel), replacing the fixed ROM image at run time.
- Assembles 7-byte little-endian words, writes them at sequential addresses from 0, and verifies a trailing checksum.
- Holds the microsequencer via cpu_hold from load start until load completion.

---
 rtl/mcram_loader_if.sv | 28 ++
 rtl/mcram_loader.sv | 184 ++++++++++++++++++
 tb/tb_mcram_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcram_loader_if.sv
// mcram_loader_if
//   Byte-stream input and microcode RAM write port of the microcode loader.
//   master : the environment side. It drives the stream and observes RAM writes.
//   slave  : the loader side.
//   Signals:
//     s_data/s_valid/s_ready  stream byte handshake (transfer on s_valid & s_ready)
//     wr_en/wr_addr/wr_data   one-cycle RAM write strobe with address and word
interface mcram_loader_if #(
  parameter int AW = 10,
  parameter int DW = 56
);
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/mcram_loader.sv
// mcram_loader
//   Writer side of the RAM-based microcode store. It takes a byte stream with
//   this format:
//     count[7:0], count[15:8], count * NB data bytes, checksum byte.
//   It assembles each group of NB little-endian bytes into one DW-bit word and
//   writes that word at sequential addresses starting at 0. At the end it checks
//   that the data bytes plus the checksum byte sum to 0 mod 256.
//   cpu_hold stalls the microsequencer from load start until the load completes.
//   After a failed load, cpu_hold stays high.
//   Ports:
//     clk, reset_n     clock, asynchronous active-low reset
//     start            one-cycle pulse; starts a load from IDLE/DONE/ERR
//     bus (slave)      stream input and RAM write port
//     cpu_hold         stall request to the microsequencer
//     busy             load in progress
//     done / err       sticky load result until the next start
//     words            number of words written in the current/last load
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no load since reset
// S_CNT0  | waiting for count low byte
// S_CNT1  | waiting for count high byte, range-checked on arrival
// S_DATA  | collecting the NB bytes of the current word
// S_WRITE | one-cycle RAM write of the assembled word
// S_CSUM  | waiting for the checksum byte
// S_DONE  | load completed with good checksum, sequencer released
// S_ERR   | bad count or checksum, sequencer kept on hold
module mcram_loader #(
  parameter int AW = 10,
  parameter int DW = 56
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  mcram_loader_if.slave bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words
);
  // DW must be a whole number of bytes.
  localparam int NB = DW / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [16:0] DEPTH = 17'(2 ** AW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT0,
    S_CNT1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state, state_nxt;

  logic          rdy_q;
  logic          wen_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [15:0]   count;
  logic [7:0]    sum;
  logic [IW-1:0] idx;

  logic          acc;
  logic          load_go;
  logic          last_byte;
  logic          more;
  logic          csum_ok;
  logic          cnt_bad;
  logic [15:0]   cnt_full;
  logic [AW:0]   words_inc;

  logic          rdy_nxt;
  logic          busy_nxt;
  logic          hold_nxt;

  assign acc       = bus.s_valid & rdy_q;
  assign load_go   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign last_byte = (idx == IW'(NB - 1));
  assign words_inc = words + 1'b1;
  assign more      = 17'(words_inc) < {1'b0, count};
  assign csum_ok   = (8'(sum + bus.s_data) == 8'h00);
  assign cnt_full  = {bus.s_data, count[7:0]};
  assign cnt_bad   = (cnt_full == 16'h0000) | ({1'b0, cnt_full} > DEPTH);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_CNT0;
      S_CNT0:  if (acc) state_nxt = S_CNT1;
      S_CNT1:  if (acc) state_nxt = cnt_bad ? S_ERR : S_DATA;
      S_DATA:  if (acc && last_byte) state_nxt = S_WRITE;
      S_WRITE: state_nxt = more ? S_DATA : S_CSUM;
      S_CSUM:  if (acc) state_nxt = csum_ok ? S_DONE : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state and registered. This way
  // they line up with the state they describe and never glitch.
  always_comb begin
    rdy_nxt  = 1'b0;
    busy_nxt = 1'b0;
    hold_nxt = 1'b0;
    unique case (state_nxt)
      S_CNT0, S_CNT1, S_DATA, S_CSUM: begin
        rdy_nxt  = 1'b1;
        busy_nxt = 1'b1;
        hold_nxt = 1'b1;
      end
      S_WRITE: begin
        busy_nxt = 1'b1;
        hold_nxt = 1'b1;
      end
      // The image is invalid after a failed load, so the sequencer stays held.
      S_ERR:   hold_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      rdy_q    <= 1'b0;
      wen_q    <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      rdy_q    <= rdy_nxt;
      wen_q    <= (state_nxt == S_WRITE);
      busy     <= busy_nxt;
      cpu_hold <= hold_nxt;
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      count  <= '0;
      sum    <= '0;
      idx    <= '0;
      words  <= '0;
    end else begin
      if (load_go) begin
        addr_q <= '0;
        sum    <= '0;
        idx    <= '0;
        words  <= '0;
      end
      if (state == S_CNT0 && acc) count[7:0]  <= bus.s_data;
      if (state == S_CNT1 && acc) count[15:8] <= bus.s_data;
      if (state == S_DATA && acc) begin
        for (int i = 0; i < NB; i++) begin
          if (idx == IW'(i)) data_q[8*i +: 8] <= bus.s_data;
        end
        sum <= sum + bus.s_data;
        idx <= last_byte ? '0 : idx + 1'b1;
      end
      // On the last word of a full-depth load, the address wraps to 0. No
      // further write follows, so the wrap is harmless.
      if (state == S_WRITE) begin
        words  <= words_inc;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign bus.s_ready = rdy_q;
  assign bus.wr_en   = wen_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;

endmodule

// File: tb/tb_mcram_loader.sv
// tb_mcram_loader
//   Drives random and fixed byte streams into mcram_loader. It builds the
//   expected RAM writes and the expected load result from the word list and the
//   stream format. It then compares them against the writes seen on the bus and
//   against the status outputs.
module tb_mcram_loader;
  localparam int AW = 10;
  localparam int DW = 56;
  localparam int NB = DW / 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words;

  mcram_loader_if #(.AW(AW), .DW(DW)) bus ();

  mcram_loader #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .words    (words)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] exp_words[$];
  int            wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wq_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(int'(bus.wr_addr));
      wq_data.push_back(bus.wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    logic rdy;
    int   n;
    repeat ($urandom_range(0, max_gap)) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        check("ready_timeout", 1, 0);
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    logic [DW-1:0] w;
    exp_words.delete();
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      exp_words.push_back(w);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one load of cnt words taken from exp_words.
  //   csum_off : added to the correct checksum byte (0 means a good checksum)
  //   abort_at : data-byte index at which reset is asserted (-1 means never)
  //   start_at : data-byte index before which a stray start is pulsed (-1 means never)
  task automatic run_load(input int cnt, input int csum_off, input int max_gap,
                          input int abort_at, input int start_at);
    logic [15:0]   c16;
    logic [7:0]    b;
    logic [7:0]    s;
    logic [7:0]    c;
    logic [DW-1:0] w;
    int            nb;
    int            nbad;
    bit            cnt_ok;
    bit            exp_ok;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    c16    = 16'(cnt);
    cnt_ok = (cnt >= 1) && (cnt <= (1 << AW));
    exp_ok = cnt_ok && (csum_off == 0);

    pulse_start();
    check("start_busy", busy, 1);
    check("start_hold", cpu_hold, 1);
    check("start_done", done, 0);
    check("start_err", err, 0);
    check("start_words", words, 0);
    check("start_ready", bus.s_ready, 1);

    send_byte(c16[7:0], max_gap);
    send_byte(c16[15:8], max_gap);
    if (!cnt_ok) begin
      check("badcnt_err", err, 1);
      check("badcnt_ready", bus.s_ready, 0);
      check("badcnt_busy", busy, 0);
      check("badcnt_hold", cpu_hold, 1);
      @(posedge clk); #1;
      check("badcnt_writes", wq_addr.size(), 0);
      return;
    end

    s  = 8'h00;
    nb = 0;
    for (int wi = 0; wi < cnt; wi++) begin
      w = exp_words[wi];
      for (int k = 0; k < NB; k++) begin
        if (nb == abort_at) begin
          reset_n = 1'b0;
          #1;
          check("rst_ready", bus.s_ready, 0);
          check("rst_wr_en", bus.wr_en, 0);
          check("rst_hold", cpu_hold, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_err", err, 0);
          check("rst_words", words, 0);
          check("rst_addr", bus.wr_addr, 0);
          check("rst_data", bus.wr_data, 0);
          @(posedge clk); #1;
          reset_n = 1'b1;
          @(posedge clk); #1;
          return;
        end
        if (nb == start_at) pulse_start();
        b = w[8*k +: 8];
        s = s + b;
        send_byte(b, max_gap);
        nb++;
      end
    end
    c = 8'(256 - int'(s) + csum_off);
    send_byte(c, max_gap);

    check("end_done", done, exp_ok);
    check("end_err", err, !exp_ok);
    check("end_hold", cpu_hold, !exp_ok);
    check("end_busy", busy, 0);
    check("end_ready", bus.s_ready, 0);
    check("end_words", words, cnt);
    check("end_nwrites", wq_addr.size(), cnt);
    nbad = 0;
    for (int i = 0; i < wq_addr.size() && i < cnt; i++) begin
      if (wq_addr[i] != i || wq_data[i] !== exp_words[i]) nbad++;
    end
    check("write_stream", nbad, 0);
    if (max_gap == 0 && cnt >= 2 && wq_cyc.size() >= 2)
      check("write_spacing", wq_cyc[1] - wq_cyc[0], NB + 1);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", bus.s_ready, 0);
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_hold", cpu_hold, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_words", words, 0);
    check("reset_addr", bus.wr_addr, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    exp_words.delete();
    exp_words.push_back(56'h0123456789ABCD);
    exp_words.push_back(56'hFEDCBA98765432);
    run_load(2, 0, 0, -1, -1);
    run_load(2, 1, 0, -1, -1);
    run_load(2, 0, 0, -1, -1);

    run_load(0, 0, 0, -1, -1);
    run_load(16'h0401, 0, 1, -1, -1);

    fill_random(1 << AW);
    run_load(1 << AW, 0, 2, -1, -1);

    fill_random(8);
    run_load(8, 0, 0, 5 * NB + 3, -1);
    fill_random(6);
    run_load(6, 0, 1, -1, -1);

    fill_random(5);
    run_load(5, 0, 1, -1, 10);

    for (int t = 0; t < 6; t++) begin
      fill_random(int'($urandom_range(1, 20)));
      run_load(exp_words.size(), (t % 3 == 2) ? int'($urandom_range(1, 255)) : 0,
               int'($urandom_range(0, 3)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
